// File: rtl/sound_pkg.sv
// sound_pkg
// Shared definitions for the sound mixer and its delta-sigma DAC:
//   clog2        constant ceil(log2) used to size counters and the mix bus
//   VOL_*        per-channel attenuation codes (2-bit volume register)
//   mix_state_t  states of the sequential mix sweep
package sound_pkg;

    localparam logic [1:0] VOL_X1   = 2'd0;
    localparam logic [1:0] VOL_HALF = 2'd1;
    localparam logic [1:0] VOL_QTR  = 2'd2;
    localparam logic [1:0] VOL_MUTE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        LOAD = 2'd2
    } mix_state_t;

    // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int bits;
        int rest;
        bits = 0;
        rest = value - 1;
        while (rest > 0) begin
            bits = bits + 1;
            rest = rest >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/sound_mixer_dsm_dsm1.sv
// dsm1
// First-order delta-sigma modulator: accumulator plus registered carry.
// Over 2**MW cycles with a constant level the output carries exactly
// `level` ones. The accumulator keeps its residue across level changes.
// Ports:
//   fclk     in   system clock
//   rst_n    in   synchronous reset, active low
//   level    in   MW-bit density to reproduce
//   dac_bit  out  registered carry, one bit per cycle
module dsm1 #(
    parameter int MW = 10
) (
    input  logic          fclk,
    input  logic          rst_n,
    input  logic [MW-1:0] level,
    output logic          dac_bit
);

    logic [MW-1:0] acc;
    logic [MW:0]   total;

    assign total = {1'b0, acc} + {1'b0, level};

    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            acc     <= '0;
            dac_bit <= 1'b0;
        end else begin
            acc     <= total[MW-1:0];
            dac_bit <= total[MW];
        end
    end

endmodule

// File: rtl/sound_mixer_dsm.sv
// sound_mixer_dsm
// Beeper/tape-out bit plus NCH covox-style sample channels written from the
// Z80 bus, attenuated per channel, summed by a sequential sweep once every
// MIX_DIV cycles, and played through a first-order delta-sigma DAC.
// Ports:
//   fclk        in   system clock
//   rst_n       in   synchronous reset, active low
//   din         in   Z80 data bus
//   beeper_wr   in   strobe: latch beeper bit (din[4], or din[3] when beeper_mux)
//   beeper_mux  in   beeper bit source select, sampled with beeper_wr
//   covox_wr    in   per-channel strobe: sample[i] <= din[SW-1:0]
//   vol_wr      in   per-channel strobe: vol[i] <= din[1:0]
//   sound_bit   out  delta-sigma bitstream to the beep pin
//   mix_dbg     out  currently held mix value
//
// Mix sweep states:
//   state | meaning
//   IDLE  | waiting for the mix tick
//   SUM   | adding attenuated sample[ch], one channel per cycle
//   LOAD  | publishing the finished sum on mix_dbg
module sound_mixer_dsm
    import sound_pkg::*;
#(
    parameter  int NCH        = 2,
    parameter  int SW         = 8,
    parameter  int BEEP_LEVEL = 255,
    parameter  int MIX_DIV    = 64,
    localparam int MW         = clog2(NCH * (2**SW - 1) + BEEP_LEVEL + 1)
) (
    input  logic           fclk,
    input  logic           rst_n,
    input  logic [7:0]     din,
    input  logic           beeper_wr,
    input  logic           beeper_mux,
    input  logic [NCH-1:0] covox_wr,
    input  logic [NCH-1:0] vol_wr,
    output logic           sound_bit,
    output logic [MW-1:0]  mix_dbg
);

    localparam int CW  = clog2(MIX_DIV);
    localparam int CHW = (NCH > 1) ? clog2(NCH) : 1;

    if (NCH < 1 || NCH > 8) begin : g_nch_chk
        $error("sound_mixer_dsm: NCH must be in 1..8");
    end
    if (SW > 8) begin : g_sw_chk
        $error("sound_mixer_dsm: SW must be <= 8");
    end
    if (BEEP_LEVEL >= 2**SW) begin : g_beep_chk
        $error("sound_mixer_dsm: BEEP_LEVEL must be < 2**SW");
    end
    if (MIX_DIV < NCH + 2) begin : g_div_chk
        $error("sound_mixer_dsm: MIX_DIV must be >= NCH+2");
    end

    logic [SW-1:0] sample [NCH];
    logic [1:0]    vol    [NCH];
    logic          beep;

    logic [CW-1:0] tick_cnt;
    logic          tick;

    mix_state_t    state, state_nxt;
    logic [MW-1:0] sum, sum_nxt;
    logic [CHW-1:0] ch, ch_nxt;
    logic [MW-1:0] mix_nxt;
    logic [SW-1:0] att;

    // Register file: every strobe in a cycle applies, each from din.
    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            beep <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                sample[i] <= '0;
                vol[i]    <= VOL_X1;
            end
        end else begin
            if (beeper_wr) begin
                beep <= beeper_mux ? din[3] : din[4];
            end
            for (int i = 0; i < NCH; i++) begin
                if (covox_wr[i]) begin
                    sample[i] <= din[SW-1:0];
                end
                if (vol_wr[i]) begin
                    vol[i] <= din[1:0];
                end
            end
        end
    end

    assign tick = (tick_cnt == CW'(MIX_DIV - 1));

    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Attenuator reads the live sample, so a write landing mid-sweep is
    // picked up only if the sweep has not yet reached that channel.
    always_comb begin
        att = '0;
        case (vol[ch])
            VOL_X1:   att = sample[ch];
            VOL_HALF: att = sample[ch] >> 1;
            VOL_QTR:  att = sample[ch] >> 2;
            default:  att = '0;
        endcase
    end

    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sum     <= '0;
            ch      <= '0;
            mix_dbg <= '0;
        end else begin
            state   <= state_nxt;
            sum     <= sum_nxt;
            ch      <= ch_nxt;
            mix_dbg <= mix_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sum_nxt   = sum;
        ch_nxt    = ch;
        mix_nxt   = mix_dbg;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt = SUM;
                    sum_nxt   = beep ? MW'(BEEP_LEVEL) : '0;
                    ch_nxt    = '0;
                end
            end
            SUM: begin
                sum_nxt = sum + MW'(att);
                if (ch == CHW'(NCH - 1)) begin
                    state_nxt = LOAD;
                end else begin
                    ch_nxt = ch + 1'b1;
                end
            end
            LOAD: begin
                mix_nxt   = sum;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    dsm1 #(.MW(MW)) u_dsm (
        .fclk    (fclk),
        .rst_n   (rst_n),
        .level   (mix_dbg),
        .dac_bit (sound_bit)
    );

endmodule

// File: tb/tb_sound_mixer_dsm.sv
// tb_sound_mixer_dsm
// Directed scenarios plus a randomized phase. The reference model keeps the
// architectural registers and a short per-cycle history; each sweep result is
// computed from the mixing rule: beeper level at the tick cycle plus each
// channel's attenuated sample as it stood in cycle tick+1+i.
module tb_sound_mixer_dsm;

    localparam int NCH   = 2;
    localparam int SW    = 8;
    localparam int BL    = 255;
    localparam int DIV   = 64;
    localparam int MW    = 10;
    localparam int HIST  = 8;

    logic           fclk;
    logic           rst_n;
    logic [7:0]     din;
    logic           beeper_wr;
    logic           beeper_mux;
    logic [NCH-1:0] covox_wr;
    logic [NCH-1:0] vol_wr;
    logic           sound_bit;
    logic [MW-1:0]  mix_dbg;

    sound_mixer_dsm #(
        .NCH(NCH), .SW(SW), .BEEP_LEVEL(BL), .MIX_DIV(DIV)
    ) dut (
        .fclk       (fclk),
        .rst_n      (rst_n),
        .din        (din),
        .beeper_wr  (beeper_wr),
        .beeper_mux (beeper_mux),
        .covox_wr   (covox_wr),
        .vol_wr     (vol_wr),
        .sound_bit  (sound_bit),
        .mix_dbg    (mix_dbg)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    int n_checks = 0;
    int n_errors = 0;

    int m_samp [NCH];
    int m_vol  [NCH];
    int m_beep;
    int h_samp [NCH][HIST];
    int h_vol  [NCH][HIST];
    int h_beep [HIST];
    int cyc;
    int exp_mix;

    task automatic check_eq(input string tag, input int obs, input int exp_val);
        n_checks++;
        if (obs != exp_val) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_val, cyc);
        end
    endtask

    function automatic int attenuate(input int s, input int v);
        if (v == 3) return 0;
        return s / (1 << v);
    endfunction

    // Called at each rising edge with the inputs of the cycle that just ended.
    task automatic model_edge();
        int t;
        int v;
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_samp[i] = 0;
                m_vol[i]  = 0;
            end
            m_beep  = 0;
            cyc     = 0;
            exp_mix = 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                h_samp[i][cyc % HIST] = m_samp[i];
                h_vol[i][cyc % HIST]  = m_vol[i];
            end
            h_beep[cyc % HIST] = m_beep;
            // cyc is the last cycle before a result published for tick t
            if (cyc >= NCH + 1) begin
                t = cyc - (NCH + 1);
                if (t % DIV == DIV - 1) begin
                    v = (h_beep[t % HIST] != 0) ? BL : 0;
                    for (int i = 0; i < NCH; i++) begin
                        v += attenuate(h_samp[i][(t + 1 + i) % HIST],
                                       h_vol[i][(t + 1 + i) % HIST]);
                    end
                    exp_mix = v;
                end
            end
            if (beeper_wr) m_beep = beeper_mux ? int'(din[3]) : int'(din[4]);
            for (int i = 0; i < NCH; i++) begin
                if (covox_wr[i]) m_samp[i] = int'(din);
                if (vol_wr[i])   m_vol[i]  = int'(din[1:0]);
            end
            cyc++;
        end
    endtask

    task automatic cycle();
        @(posedge fclk);
        model_edge();
        #1;
        beeper_wr = 1'b0;
        covox_wr  = '0;
        vol_wr    = '0;
        @(negedge fclk);
        check_eq("mix_model", int'(mix_dbg), exp_mix);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (4) cycle();
        check_eq("reset_mix", int'(mix_dbg), 0);
        check_eq("reset_bit", int'(sound_bit), 0);
        rst_n = 1'b1;
    endtask

    // Let a write driven now land, then wait until a sweep that saw it has published.
    task automatic settle();
        cycle();
        while (cyc % DIV != DIV - 1) cycle();
        while (cyc % DIV != 3) cycle();
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        repeat (n) begin
            cycle();
            ones += int'(sound_bit);
        end
    endtask

    task automatic wr_covox(input logic [NCH-1:0] mask, input logic [7:0] d);
        covox_wr = mask;
        din      = d;
    endtask

    task automatic wr_vol(input logic [NCH-1:0] mask, input logic [7:0] d);
        vol_wr = mask;
        din    = d;
    endtask

    task automatic wr_beep(input logic mux, input logic [7:0] d);
        beeper_wr  = 1'b1;
        beeper_mux = mux;
        din        = d;
    endtask

    initial begin
        int ones;
        rst_n      = 1'b0;
        din        = '0;
        beeper_wr  = 1'b0;
        beeper_mux = 1'b0;
        covox_wr   = '0;
        vol_wr     = '0;
        cyc        = 0;
        exp_mix    = 0;

        // 1: idle after reset
        do_reset();
        count_ones(2048, ones);
        check_eq("idle_ones", ones, 0);

        // 2: single channel, DSM density
        wr_covox(2'b01, 8'h80);
        settle();
        check_eq("ch0_128", int'(mix_dbg), 128);
        count_ones(1024, ones);
        check_eq("dsm_win1", ones, 128);
        count_ones(1024, ones);
        check_eq("dsm_win2", ones, 128);

        // 3: beeper source select
        do_reset();
        wr_beep(1'b0, 8'h10);
        settle();
        check_eq("beep_d4", int'(mix_dbg), 255);
        wr_beep(1'b0, 8'h08);
        settle();
        check_eq("beep_d4_clr", int'(mix_dbg), 0);
        wr_beep(1'b1, 8'h08);
        settle();
        check_eq("beep_d3", int'(mix_dbg), 255);

        // 4: full scale and attenuation
        wr_covox(2'b11, 8'hFF);
        settle();
        check_eq("full_scale", int'(mix_dbg), 765);
        count_ones(1024, ones);
        check_eq("dsm_full", ones, 765);
        wr_vol(2'b10, 8'h03);
        settle();
        check_eq("vol1_mute", int'(mix_dbg), 510);
        wr_vol(2'b01, 8'h02);
        settle();
        check_eq("vol0_qtr", int'(mix_dbg), 318);

        // 5: write timing against the sweep
        do_reset();
        wr_covox(2'b01, 8'h10);
        settle();
        check_eq("t_base", int'(mix_dbg), 16);
        while (cyc % DIV != 0) cycle();
        wr_covox(2'b10, 8'h20);
        repeat (3) cycle();
        check_eq("t_sum_write", int'(mix_dbg), 48);
        while (cyc % DIV != 2) cycle();
        wr_covox(2'b10, 8'h40);
        cycle();
        check_eq("t_load_write", int'(mix_dbg), 48);
        cycle();
        while (cyc % DIV != 3) cycle();
        check_eq("t_load_next", int'(mix_dbg), 80);
        wr_covox(2'b11, 8'h05);
        settle();
        check_eq("both_ch", int'(mix_dbg), 10);
        covox_wr = 2'b01;
        vol_wr   = 2'b01;
        din      = 8'h81;
        settle();
        check_eq("vol_covox_same", int'(mix_dbg), 69);
        wr_beep(1'b0, 8'h12);
        covox_wr = 2'b10;
        settle();
        check_eq("beep_covox_same", int'(mix_dbg), 337);

        // 6: reset in the middle of a sweep
        do_reset();
        wr_covox(2'b01, 8'h40);
        settle();
        check_eq("pre_rst", int'(mix_dbg), 64);
        cycle();
        while (cyc % DIV != 0) cycle();
        rst_n = 1'b0;
        cycle();
        check_eq("midrst_mix", int'(mix_dbg), 0);
        check_eq("midrst_bit", int'(sound_bit), 0);
        rst_n = 1'b1;
        settle();
        check_eq("samples_cleared", int'(mix_dbg), 0);
        wr_covox(2'b01, 8'h40);
        settle();
        check_eq("rewrite_64", int'(mix_dbg), 64);

        // Randomized traffic, checked every cycle against the model
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            din        = 8'($urandom);
            beeper_mux = 1'($urandom);
            beeper_wr  = ($urandom_range(0, 7) == 0);
            covox_wr   = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            vol_wr     = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
            rst_n      = ($urandom_range(0, 799) != 0);
            cycle();
        end
        rst_n = 1'b1;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
